affine_interp_seq: RTL and testbench
====================================

Name: affine_interp_seq

Overview:
- Sequencer for the 6-tap, 1/16-precision affine interpolation filter.
- Accepts one interpolation request per fractional position and fetches the 6 reference samples, one per cycle, from an external sample buffer.
- Drives the shared per-tap MCM product mux with tap index and fraction, and accumulates the signed products.
- Emits one rounded, saturated interpolated sample per request over a valid/ready output.

Parameters:
- IN_SIZE, 8, bit width of signed input samples and of out_data.
- PROD_SIZE, 15, bit width of the signed product returned by the MCM mux (tap sign already applied).
- ACC_SIZE, 18, accumulator width; must be at least PROD_SIZE+3.
- SHIFT, 6, normalisation shift (filter gain 64).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_frac  in  4  fractional position 0..15; sampled on handshake.
- rd_en  out  1  sample read strobe to the buffer.
- rd_tap  out  3  tap index 0..5 being read.
- smp_data  in  IN_SIZE  signed sample, valid exactly 1 cycle after rd_en.
- mcm_x  out  IN_SIZE  registered copy of smp_data fed to the MCM mux.
- mcm_tap  out  3  tap index matching mcm_x.
- mcm_frac  out  4  latched req_frac.
- mcm_prod  in  PROD_SIZE  signed product for (mcm_x, mcm_tap, mcm_frac); combinational, same cycle.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_data  out  IN_SIZE  signed interpolated sample.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; req_ready=1; rd_en=0; rd_tap=0; mcm_x=0; mcm_tap=0; mcm_frac=0; accumulator=0; out_valid=0; out_data=0.
- States: IDLE, FETCH, DRAIN, ROUND, HOLD.
- IDLE: on req_valid&&req_ready, latch frac into mcm_frac, clear the accumulator, go to FETCH. Request handshake cycle is cycle 0.
- FETCH, frac!=0: rd_en=1 with rd_tap=0..5 on cycles 1..6; go to DRAIN after tap 5.
- FETCH, frac==0: single read, rd_tap=2 on cycle 1, then DRAIN. The integer position bypasses the MCM.
- Every cycle following an rd_en: mcm_x<=smp_data and mcm_tap<=the previous rd_tap.
- Accumulation, frac!=0: acc<=acc+sign_extend(mcm_prod) on the cycle after each mcm_x load, so on cycles 3..8 for taps 0..5.
- Accumulation, frac==0: acc<=sign_extend(mcm_x)<<SHIFT on cycle 3; mcm_prod is ignored.
- DRAIN lasts until the last accumulate completes, then ROUND.
- ROUND (1 cycle): r=(acc+2^(SHIFT-1))>>>SHIFT (arithmetic shift). Saturate r to [-2^(IN_SIZE-1), 2^(IN_SIZE-1)-1] and register it into out_data. Set out_valid=1 and go to HOLD.
- Timing at out_ready=1: frac!=0 gives out_valid on cycle 10; frac==0 gives out_valid on cycle 5.
- HOLD: out_data and out_valid are stable while out_ready=0. On out_valid&&out_ready, out_valid<=0 and state<=IDLE; req_ready rises the next cycle.
- Throughput: one request is in flight at most; no overlap between requests.
- No overflow is possible: 6 products of PROD_SIZE fit in ACC_SIZE. Arithmetic is two's complement throughout.
- req_frac changing outside the handshake has no effect.
- req_valid held high during HOLD is not accepted until IDLE.
- Reset mid-operation aborts the request: no out_valid pulse, and no rd_en after reset assertion.

Test Plan:
- DC input: frac=8, all 6 samples=10, bench MCM model with taps {3,-11,40,40,-11,3}. Expect acc=640 and out_data=10. Expect rd_tap sequence 0..5 on cycles 1..6 and out_valid on cycle 10.
- Integer bypass: frac=0, tap-2 sample=37, mcm_prod forced to garbage. Expect a single rd_en with rd_tap=2, out_data=37, out_valid on cycle 5.
- Rounding: bench products summing to 95 gives out_data=1; summing to -33 gives -1; summing to 31 gives 0; summing to 32 gives 1.
- Saturation (IN_SIZE=8): products summing to 100*64 gives out_data=127; summing to -200*64 gives out_data=-128.
- Backpressure: out_ready=0 for 5 cycles with req_valid held high. out_data and out_valid stay stable and req_ready stays 0. The next request is accepted 1 cycle after the out handshake.
- Reset during FETCH at rd_tap=3: all outputs go to reset values immediately. No out_valid follows, and the next request completes correctly with frac=8 and DC=10.

Source files
------------

// File: rtl/affine_interp_seq.sv
// rtl/affine_interp_seq.sv - sequencer for the 6-tap 1/16-precision affine interpolation filter
module affine_interp_seq #(
    parameter int IN_SIZE   = 8,
    parameter int PROD_SIZE = 15,
    parameter int ACC_SIZE  = 18,
    parameter int SHIFT     = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_frac,
    output logic                 rd_en,
    output logic [2:0]           rd_tap,
    input  logic [IN_SIZE-1:0]   smp_data,
    output logic [IN_SIZE-1:0]   mcm_x,
    output logic [2:0]           mcm_tap,
    output logic [3:0]           mcm_frac,
    input  logic [PROD_SIZE-1:0] mcm_prod,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IN_SIZE-1:0]   out_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_ROUND,
        S_HOLD
    } state_t;

    localparam logic [2:0] LAST_TAP = 3'd5;
    localparam logic [2:0] INT_TAP  = 3'd2;

    localparam logic signed [ACC_SIZE-1:0] RND_C   = ACC_SIZE'(2 ** (SHIFT - 1));
    localparam logic signed [ACC_SIZE-1:0] SAT_MAX = ACC_SIZE'(2 ** (IN_SIZE - 1) - 1);
    localparam logic signed [ACC_SIZE-1:0] SAT_MIN = ACC_SIZE'(-(2 ** (IN_SIZE - 1)));

    state_t                      state_q, state_d;
    logic [2:0]                  tap_q, tap_d;
    logic [3:0]                  frac_q, frac_d;
    logic                        ld_q;
    logic [2:0]                  ld_tap_q;
    logic                        acc_en_q;
    logic [IN_SIZE-1:0]          mcm_x_q;
    logic [2:0]                  mcm_tap_q;
    logic signed [ACC_SIZE-1:0]  acc_q, acc_d;
    logic                        out_valid_q, out_valid_d;
    logic [IN_SIZE-1:0]          out_data_q, out_data_d;

    logic                        req_hs;
    logic                        fetch_last;
    logic signed [ACC_SIZE-1:0]  prod_ext;
    logic signed [ACC_SIZE-1:0]  x_scaled;
    logic signed [ACC_SIZE-1:0]  rnd_sum;
    logic signed [ACC_SIZE-1:0]  rnd_val;

    assign req_ready  = (state_q == S_IDLE);
    assign rd_en      = (state_q == S_FETCH);
    assign rd_tap     = tap_q;
    assign mcm_x      = mcm_x_q;
    assign mcm_tap    = mcm_tap_q;
    assign mcm_frac   = frac_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;

    assign req_hs     = req_valid && (state_q == S_IDLE);
    // The integer position needs only the centre sample, so it ends after one read.
    assign fetch_last = (frac_q == 4'd0) || (tap_q == LAST_TAP);

    assign prod_ext = {{(ACC_SIZE-PROD_SIZE){mcm_prod[PROD_SIZE-1]}}, mcm_prod};
    assign x_scaled = {{(ACC_SIZE-IN_SIZE){mcm_x_q[IN_SIZE-1]}}, mcm_x_q} <<< SHIFT;
    assign rnd_sum  = acc_q + RND_C;
    assign rnd_val  = rnd_sum >>> SHIFT;

    // Next-state, tap counter, accumulator and output register updates.
    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        frac_d      = frac_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (acc_en_q) begin
            if (frac_q == 4'd0) begin
                acc_d = x_scaled;
            end else begin
                acc_d = acc_q + prod_ext;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (req_hs) begin
                    frac_d  = req_frac;
                    acc_d   = '0;
                    tap_d   = (req_frac == 4'd0) ? INT_TAP : 3'd0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (fetch_last) begin
                    tap_d   = 3'd0;
                    state_d = S_DRAIN;
                end else begin
                    tap_d = tap_q + 3'd1;
                end
            end
            S_DRAIN: begin
                // The last accumulate happens when no further sample load is pending.
                if (acc_en_q && !ld_q) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (rnd_val > SAT_MAX) begin
                    out_data_d = SAT_MAX[IN_SIZE-1:0];
                end else if (rnd_val < SAT_MIN) begin
                    out_data_d = SAT_MIN[IN_SIZE-1:0];
                end else begin
                    out_data_d = rnd_val[IN_SIZE-1:0];
                end
                out_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tap_q       <= '0;
            frac_q      <= '0;
            ld_q        <= 1'b0;
            ld_tap_q    <= '0;
            acc_en_q    <= 1'b0;
            mcm_x_q     <= '0;
            mcm_tap_q   <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            frac_q      <= frac_d;
            ld_q        <= rd_en;
            ld_tap_q    <= rd_tap;
            acc_en_q    <= ld_q;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            if (ld_q) begin
                mcm_x_q   <= smp_data;
                mcm_tap_q <= ld_tap_q;
            end
        end
    end

endmodule

// File: tb/tb_affine_interp_seq.sv
// tb/tb_affine_interp_seq.sv - self-checking bench for affine_interp_seq
module tb_affine_interp_seq;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_frac;
    logic        rd_en;
    logic [2:0]  rd_tap;
    logic [7:0]  smp_data;
    logic [7:0]  mcm_x;
    logic [2:0]  mcm_tap;
    logic [3:0]  mcm_frac;
    logic [14:0] mcm_prod;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;

    int checks = 0;
    int errors = 0;

    int smp_tbl[8];
    int prod_tbl[8];
    int coef[8];
    bit use_coef;

    affine_interp_seq #(
        .IN_SIZE(8), .PROD_SIZE(15), .ACC_SIZE(18), .SHIFT(6)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_frac(req_frac),
        .rd_en(rd_en), .rd_tap(rd_tap), .smp_data(smp_data),
        .mcm_x(mcm_x), .mcm_tap(mcm_tap), .mcm_frac(mcm_frac), .mcm_prod(mcm_prod),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample buffer: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en) smp_data <= 8'(smp_tbl[rd_tap]);
        else       smp_data <= 8'h5A;
    end

    // MCM mux: either real filter coefficients or a forced product table.
    always_comb begin
        if (use_coef) mcm_prod = 15'(coef[mcm_tap] * int'($signed(mcm_x)));
        else          mcm_prod = 15'(prod_tbl[mcm_tap]);
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Filter output from the sample/product tables: rounded, floor-divided, clamped.
    function automatic int model_out(input logic [3:0] f);
        int s, q;
        s = 0;
        if (f == 4'd0) s = smp_tbl[2] * 64;
        else for (int t = 0; t < 6; t++) s += use_coef ? coef[t] * smp_tbl[t] : prod_tbl[t];
        s = s + 32;
        q = s / 64;
        if (s < 0 && (s % 64) != 0) q = q - 1;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    // Cycle-accurate monitor: cycle 0 is the request handshake cycle.
    bit       busy = 0;
    int       cyc, lat, exp_o, exp_tap;
    bit       exp_rd;
    logic [3:0] cur_f;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy = 0;
        end else if (busy) begin
            cyc++;
            chk("req_ready_busy", int'(req_ready), 0);
            exp_rd = (cur_f != 0) ? (cyc >= 1 && cyc <= 6) : (cyc == 1);
            chk("rd_en", int'(rd_en), int'(exp_rd));
            if (exp_rd) begin
                exp_tap = (cur_f != 0) ? cyc - 1 : 2;
                chk("rd_tap", int'(rd_tap), exp_tap);
            end
            chk("out_valid_timing", int'(out_valid), int'(cyc >= lat));
            if (out_valid) chk("out_data", int'($signed(out_data)), exp_o);
            if (out_valid && out_ready) busy = 0;
            if (cyc > 200) begin
                chk("monitor_timeout", cyc, 0);
                busy = 0;
            end
        end else begin
            chk("req_ready_idle", int'(req_ready), 1);
            chk("rd_en_idle", int'(rd_en), 0);
            chk("out_valid_idle", int'(out_valid), 0);
            if (req_valid && req_ready) begin
                busy  = 1;
                cyc   = 0;
                cur_f = req_frac;
                lat   = (req_frac != 0) ? 10 : 5;
                exp_o = model_out(req_frac);
            end
        end
    end

    task automatic issue_req(input logic [3:0] f, input bit keep_valid);
        bit ok;
        ok = 0;
        req_frac  = f;
        req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) chk("req_accept_timeout", 0, 1);
        @(posedge clk); #1;
        if (!keep_valid) req_valid = 1'b0;
        req_frac = ~f;
    endtask

    task automatic wait_out(output int got);
        bit ok;
        ok = 0;
        got = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                got = int'($signed(out_data));
                ok = 1;
                break;
            end
        end
        if (!ok) chk("out_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_req(input logic [3:0] f, input int hand, input string nm);
        int got;
        chk({nm, "_model"}, model_out(f), hand);
        issue_req(f, 1'b0);
        wait_out(got);
        chk(nm, got, hand);
    endtask

    task automatic set_dc(input int v);
        use_coef = 1;
        for (int i = 0; i < 8; i++) smp_tbl[i] = v;
    endtask

    task automatic set_prods(input int p0, input int p1, input int p2, input int p3);
        use_coef = 0;
        prod_tbl[0] = p0; prod_tbl[1] = p1; prod_tbl[2] = p2; prod_tbl[3] = p3;
        prod_tbl[4] = 0;  prod_tbl[5] = 0;  prod_tbl[6] = 0;  prod_tbl[7] = 0;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_req_ready"}, int'(req_ready), 1);
        chk({nm, "_rd_en"}, int'(rd_en), 0);
        chk({nm, "_rd_tap"}, int'(rd_tap), 0);
        chk({nm, "_mcm_x"}, int'(mcm_x), 0);
        chk({nm, "_mcm_tap"}, int'(mcm_tap), 0);
        chk({nm, "_mcm_frac"}, int'(mcm_frac), 0);
        chk({nm, "_out_valid"}, int'(out_valid), 0);
        chk({nm, "_out_data"}, int'(out_data), 0);
    endtask

    initial begin
        int got, held;
        bit ok;
        coef = '{3, -11, 40, 40, -11, 3, 0, 0};
        for (int i = 0; i < 8; i++) begin smp_tbl[i] = 0; prod_tbl[i] = 0; end
        use_coef  = 1;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_frac  = 4'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // DC input through the real coefficient set.
        set_dc(10);
        run_req(4'd8, 10, "dc_frac8");

        // Integer bypass with garbage products.
        use_coef = 0;
        for (int i = 0; i < 8; i++) begin
            smp_tbl[i]  = 99;
            prod_tbl[i] = int'($urandom_range(0, 30000)) - 15000;
        end
        smp_tbl[2] = 37;
        run_req(4'd0, 37, "bypass");
        smp_tbl[2] = -50;
        run_req(4'd0, -50, "bypass_neg");

        // Rounding edges.
        set_prods(50, 45, 0, 0);        run_req(4'd5, 1, "round_95");
        set_prods(-40, 7, 0, 0);        run_req(4'd3, -1, "round_m33");
        set_prods(31, 0, 0, 0);         run_req(4'd15, 0, "round_31");
        set_prods(16, 0, 0, 16);        run_req(4'd1, 1, "round_32");

        // Saturation and its near-boundary neighbour.
        set_prods(6400, 0, 0, 0);       run_req(4'd7, 100, "sat_100x64");
        set_prods(6400, 6400, 0, 0);    run_req(4'd7, 127, "sat_pos");
        set_prods(-6400, -6400, 0, 0);  run_req(4'd9, -128, "sat_neg");

        // Backpressure with a second request held pending.
        set_dc(10);
        out_ready = 1'b0;
        issue_req(4'd8, 1'b1);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        if (!ok) chk("bp_valid_timeout", 0, 1);
        held = int'($signed(out_data));
        chk("bp_first_data", held, 10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_stable", int'(out_valid), 1);
            chk("bp_data_stable", int'($signed(out_data)), held);
            chk("bp_req_ready_low", int'(req_ready), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_out_hs", int'(out_valid), 1);
        @(negedge clk);
        chk("bp_next_accept", int'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_out(got);
        chk("bp_second_req", got, 10);

        // Reset in the middle of the fetch.
        set_dc(10);
        issue_req(4'd8, 1'b0);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_en && rd_tap == 3'd3) begin ok = 1; break; end
        end
        if (!ok) chk("rst_tap3_timeout", 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("midrst_no_valid", int'(out_valid), 0);
            chk("midrst_no_rd", int'(rd_en), 0);
        end
        @(posedge clk); #1;
        run_req(4'd8, 10, "after_rst_dc");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
